// File: rtl/mux8_pkg.sv
`default_nettype none
// ============================================================================
// Module : mux8_pkg
// Brief  : Shared types, widths and select helpers for the mux8 serializer.
// Rev    : 1.0  initial release
// ============================================================================
package mux8_pkg;

    localparam int SEL_W = 3;
    localparam int N_IN  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    function automatic logic [SEL_W-1:0] first_sel(input logic msb_first);
        return msb_first ? SEL_W'(N_IN - 1) : SEL_W'(0);
    endfunction

    function automatic logic [SEL_W-1:0] last_sel(input logic msb_first);
        return msb_first ? SEL_W'(0) : SEL_W'(N_IN - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muxer8.sv
`default_nettype none
// ============================================================================
// Module : muxer8
// Brief  : Purely combinational 8:1 bit multiplexer.
// Rev    : 1.0  initial release
// ============================================================================
module muxer8
    import mux8_pkg::*;
(
    input  logic [N_IN-1:0]  in,
    input  logic [SEL_W-1:0] sel,
    output logic             q
);

    assign q = in[sel];

endmodule
`default_nettype wire

// File: rtl/mux8_ser_ctrl.sv
`default_nettype none
// ============================================================================
// Module : mux8_ser_ctrl
// Brief  : Byte-in handshake controller that walks a muxer8 select through all
//          eight positions, producing a framed serial bit stream.
// Rev    : 1.0  initial release
// ============================================================================
module mux8_ser_ctrl
    import mux8_pkg::*;
#(
    parameter int BIT_DIV   = 1,
    parameter bit MSB_FIRST = 1'b0
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic [SEL_W-1:0] sel_mon,
    output logic             busy
);

    localparam int                c_DIV_W    = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(BIT_DIV - 1);
    localparam logic [SEL_W-1:0]  c_FIRST    = first_sel(MSB_FIRST);
    localparam logic [SEL_W-1:0]  c_LAST     = last_sel(MSB_FIRST);

    ser_state_t         r_state;
    logic [N_IN-1:0]    r_hold;
    logic [SEL_W-1:0]   r_sel;
    logic [c_DIV_W-1:0] r_div;

    logic               w_shift;
    logic               w_bit_end;
    logic               w_last;
    logic               w_ready;
    logic               w_take;
    logic               w_mux_q;
    logic [SEL_W-1:0]   w_sel_next;

    assign w_shift    = (r_state == SHIFT);
    assign w_bit_end  = (r_div == c_DIV_LAST);
    assign w_last     = w_shift && w_bit_end && (r_sel == c_LAST);
    // Ready is gated by rst directly so it reads 0 for the whole reset pulse.
    assign w_ready    = !rst && (!w_shift || w_last);
    assign w_take     = data_valid && w_ready;
    assign w_sel_next = MSB_FIRST ? (r_sel - SEL_W'(1)) : (r_sel + SEL_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_hold  <= '0;
            r_sel   <= c_FIRST;
            r_div   <= '0;
        end else if (r_state == IDLE) begin
            if (w_take) begin
                r_hold  <= data_in;
                r_sel   <= c_FIRST;
                r_div   <= '0;
                r_state <= SHIFT;
            end
        end else begin
            if (w_bit_end) begin
                r_div <= '0;
                if (w_take) begin
                    r_hold <= data_in;
                    r_sel  <= c_FIRST;
                end else begin
                    // On the last bit this wraps sel back to the first index.
                    r_sel <= w_sel_next;
                    if (w_last) begin
                        r_state <= IDLE;
                    end
                end
            end else begin
                r_div <= r_div + c_DIV_W'(1);
            end
        end
    end

    muxer8 u_mux (
        .in  (r_hold),
        .sel (r_sel),
        .q   (w_mux_q)
    );

    assign data_ready  = w_ready;
    assign ser_out     = w_shift && w_mux_q;
    assign ser_valid   = w_shift;
    assign busy        = w_shift;
    assign frame_start = w_shift && (r_sel == c_FIRST);
    assign frame_end   = w_last;
    assign sel_mon     = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_mux8_ser_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_mux8_ser_ctrl
// Brief  : Self-checking bench driving three serializer configurations in
//          parallel against a per-cycle frame model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mux8_ser_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;

    logic [2:0] w_rdy, w_ser, w_sv, w_fs, w_fe, w_busy;
    logic [2:0] w_sel [3];

    int checks = 0;
    int errors = 0;

    // Model state per instance: active flag, cycle offset within frame, byte.
    bit         act_m  [3];
    int         t_m    [3];
    logic [7:0] byte_m [3];

    always #5 clk = ~clk;

    mux8_ser_ctrl #(.BIT_DIV(1), .MSB_FIRST(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .data_ready(w_rdy[0]), .ser_out(w_ser[0]), .ser_valid(w_sv[0]),
        .frame_start(w_fs[0]), .frame_end(w_fe[0]), .sel_mon(w_sel[0]), .busy(w_busy[0])
    );

    mux8_ser_ctrl #(.BIT_DIV(3), .MSB_FIRST(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .data_ready(w_rdy[1]), .ser_out(w_ser[1]), .ser_valid(w_sv[1]),
        .frame_start(w_fs[1]), .frame_end(w_fe[1]), .sel_mon(w_sel[1]), .busy(w_busy[1])
    );

    mux8_ser_ctrl #(.BIT_DIV(1), .MSB_FIRST(1'b1)) u_dut2 (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .data_ready(w_rdy[2]), .ser_out(w_ser[2]), .ser_valid(w_sv[2]),
        .frame_start(w_fs[2]), .frame_end(w_fe[2]), .sel_mon(w_sel[2]), .busy(w_busy[2])
    );

    function automatic int bd_of(input int i);
        return (i == 1) ? 3 : 1;
    endfunction

    function automatic bit msb_of(input int i);
        return (i == 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // {ready, ser_out, ser_valid, frame_start, frame_end, busy, sel[2:0]}
    function automatic logic [8:0] exp_vec(input int i);
        int         bd   = bd_of(i);
        int         last = 8 * bd - 1;
        int         idx  = t_m[i] / bd;
        int         bpos = msb_of(i) ? (7 - idx) : idx;
        logic [2:0] sel  = act_m[i] ? 3'(bpos) : (msb_of(i) ? 3'd7 : 3'd0);
        logic       ser  = act_m[i] ? byte_m[i][bpos] : 1'b0;
        logic       rdy  = !act_m[i] || (t_m[i] == last);
        logic       fs   = act_m[i] && (t_m[i] < bd);
        logic       fe   = act_m[i] && (t_m[i] == last);
        return {rdy, ser, act_m[i], fs, fe, act_m[i], sel};
    endfunction

    function automatic logic [8:0] act_vec(input int i);
        return {w_rdy[i], w_ser[i], w_sv[i], w_fs[i], w_fe[i], w_busy[i], w_sel[i]};
    endfunction

    task automatic tick();
        bit hs [3];
        for (int i = 0; i < 3; i++)
            hs[i] = data_valid && (!act_m[i] || (t_m[i] == 8 * bd_of(i) - 1));
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (act_m[i]) begin
                t_m[i]++;
                if (t_m[i] == 8 * bd_of(i)) act_m[i] = 1'b0;
            end
            if (hs[i]) begin
                act_m[i]  = 1'b1;
                t_m[i]    = 0;
                byte_m[i] = data_in;
            end
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (act_vec(i) !== exp_vec(i)) begin
                errors++;
                $display("FAIL model_u%0d: got %b expected %b", i, act_vec(i), exp_vec(i));
            end
        end
    endtask

    // Async assert between edges; outputs must drop without any clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            act_m[i] = 1'b0;
            t_m[i]   = 0;
            chk($sformatf("rst_outs_u%0d", i), 32'(act_vec(i)),
                32'({8'b0, (msb_of(i) ? 1'b1 : 1'b0)} == 9'd1 ? 9'b000000111 : 9'b0));
        end
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("rel_ready_sel_u%0d", i), 32'({w_rdy[i], w_sel[i]}),
                32'({1'b1, (msb_of(i) ? 3'd7 : 3'd0)}));
    endtask

    task automatic drain();
        int n = 0;
        data_valid = 1'b0;
        while ((act_m[0] || act_m[1] || act_m[2]) && n < 40) begin
            tick();
            n++;
        end
        chk("drain_idle", 32'(w_busy), 32'd0);
    endtask

    // Sends one byte and captures the serial streams of all three instances.
    task automatic send_collect(input logic [7:0] b, input logic [0:7] lsb, input logic [0:7] msb);
        logic [0:7]  got0, got2;
        logic [0:23] got1, exp1;
        data_in    = b;
        data_valid = 1'b1;
        for (int k = 0; k < 24; k++) begin
            tick();
            if (k == 0) begin
                data_valid = 1'b0;
                data_in    = ~b;
            end
            if (k == 4) data_in = 8'hFF;
            if (k < 8) begin
                got0[k] = w_ser[0];
                got2[k] = w_ser[2];
            end
            got1[k] = w_ser[1];
            exp1[k] = lsb[k / 3];
        end
        chk($sformatf("seq_lsb_%h", b), 32'(got0), 32'(lsb));
        chk($sformatf("seq_msb_%h", b), 32'(got2), 32'(msb));
        chk($sformatf("seq_div3_%h", b), 32'(got1), 32'(exp1));
        drain();
    endtask

    typedef struct {
        logic [7:0] b;
        logic [0:7] lsb;
        logic [0:7] msb;
    } vec_t;

    initial begin
        vec_t       tbl [5];
        logic [0:15] got16;
        logic [15:0] sv16;

        tbl[0] = '{b: 8'hA5, lsb: 8'b10100101, msb: 8'b10100101};
        tbl[1] = '{b: 8'h01, lsb: 8'b10000000, msb: 8'b00000001};
        tbl[2] = '{b: 8'hF0, lsb: 8'b00001111, msb: 8'b11110000};
        tbl[3] = '{b: 8'h96, lsb: 8'b01101001, msb: 8'b10010110};
        tbl[4] = '{b: 8'h3C, lsb: 8'b00111100, msb: 8'b00111100};

        for (int i = 0; i < 3; i++) begin
            act_m[i]  = 1'b0;
            t_m[i]    = 0;
            byte_m[i] = 8'h00;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("init_ready_sel_u%0d", i), 32'({w_rdy[i], w_sel[i]}),
                32'({1'b1, (msb_of(i) ? 3'd7 : 3'd0)}));
        tick();

        for (int v = 0; v < 5; v++)
            send_collect(tbl[v].b, tbl[v].lsb, tbl[v].msb);

        do_reset();

        // Back-to-back frames: second byte accepted on the frame_end cycle.
        data_in    = 8'h01;
        data_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k == 9) data_valid = 1'b0;
            tick();
            if (k == 0) data_in = 8'h80;
            got16[k] = w_ser[0];
            sv16[k]  = w_sv[0];
        end
        chk("b2b_stream", 32'(got16), 32'h8001);
        chk("b2b_valid", 32'(sv16), 32'hFFFF);
        drain();

        // Abort mid-frame, then a fresh frame from the first index.
        data_in    = 8'hFF;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        repeat (3) tick();
        do_reset();
        chk("abort_valid_busy", 32'({w_sv, w_busy}), 32'd0);
        send_collect(8'h3C, 8'b00111100, 8'b00111100);

        for (int k = 0; k < 300; k++) begin
            data_valid = ($urandom_range(0, 3) != 0);
            data_in    = 8'($urandom);
            tick();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
